// File: rtl/ysyx_23060236_axi_pkg.sv
// rtl/ysyx_23060236_axi_pkg.sv - shared AXI encodings and slave FSM states
package ysyx_23060236_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_WORD   = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RWAIT,
    S_RDATA,
    S_WDATA,
    S_BRESP
  } state_e;

endpackage

// File: rtl/ysyx_23060236_sram_array.sv
// rtl/ysyx_23060236_sram_array.sv - DEPTH x 32 word array, 1-cycle read, byte-masked write
module ysyx_23060236_sram_array #(
  parameter int DEPTH = 4096,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [31:0]      rdata_o,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [3:0]       wstrb_i,
  input  logic [31:0]      wdata_i
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ysyx_23060236_axi_sram.sv
// rtl/ysyx_23060236_axi_sram.sv - single-outstanding AXI4 slave memory with programmable read latency
module ysyx_23060236_axi_sram
  import ysyx_23060236_axi_pkg::*;
#(
  parameter int                ADDR_W = 32,
  parameter int                DEPTH  = 4096,
  parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000,
  parameter int                RD_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  output logic              io_slave_awready,
  input  logic              io_slave_awvalid,
  input  logic [ADDR_W-1:0] io_slave_awaddr,
  input  logic [3:0]        io_slave_awid,
  input  logic [7:0]        io_slave_awlen,
  input  logic [2:0]        io_slave_awsize,
  input  logic [1:0]        io_slave_awburst,
  output logic              io_slave_wready,
  input  logic              io_slave_wvalid,
  input  logic [31:0]       io_slave_wdata,
  input  logic [3:0]        io_slave_wstrb,
  input  logic              io_slave_wlast,
  input  logic              io_slave_bready,
  output logic              io_slave_bvalid,
  output logic [1:0]        io_slave_bresp,
  output logic [3:0]        io_slave_bid,
  output logic              io_slave_arready,
  input  logic              io_slave_arvalid,
  input  logic [ADDR_W-1:0] io_slave_araddr,
  input  logic [3:0]        io_slave_arid,
  input  logic [7:0]        io_slave_arlen,
  input  logic [2:0]        io_slave_arsize,
  input  logic [1:0]        io_slave_arburst,
  input  logic              io_slave_rready,
  output logic              io_slave_rvalid,
  output logic [1:0]        io_slave_rresp,
  output logic [31:0]       io_slave_rdata,
  output logic              io_slave_rlast,
  output logic [3:0]        io_slave_rid
);

  localparam int IDX_W = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        id_q, id_d;
  logic [7:0]        len_q, len_d;
  logic [1:0]        burst_q, burst_d;
  logic [7:0]        beat_q, beat_d;
  logic [7:0]        lat_q, lat_d;
  logic              err_q, err_d;

  logic              arready, awready, wready, rvalid, bvalid, we;
  logic [ADDR_W-1:0] nxt_addr, rd_addr, off;
  logic              in_range;
  logic [31:0]       arr_rdata;
  logic              unused_size;

  // Every transfer is served as a 32-bit word regardless of the requested size.
  assign unused_size = (io_slave_awsize != SIZE_WORD) ^ (io_slave_arsize != SIZE_WORD);

  assign nxt_addr = (burst_q == BURST_INCR || burst_q == BURST_WRAP) ? addr_q + ADDR_W'(4) : addr_q;
  assign off      = addr_q - BASE;
  assign in_range = (addr_q >= BASE) && ((off >> 2) < ADDR_W'(DEPTH));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    id_d    = id_q;
    len_d   = len_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    err_d   = err_q;
    arready = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    rvalid  = 1'b0;
    bvalid  = 1'b0;
    we      = 1'b0;
    rd_addr = addr_q;
    unique case (state_q)
      S_IDLE: begin
        arready = 1'b1;
        awready = !io_slave_arvalid;
        if (io_slave_arvalid) begin
          addr_d  = io_slave_araddr;
          id_d    = io_slave_arid;
          len_d   = io_slave_arlen;
          burst_d = io_slave_arburst;
          beat_d  = 8'd0;
          lat_d   = 8'(RD_LAT - 1);
          state_d = S_RWAIT;
        end else if (io_slave_awvalid) begin
          addr_d  = io_slave_awaddr;
          id_d    = io_slave_awid;
          len_d   = io_slave_awlen;
          burst_d = io_slave_awburst;
          beat_d  = 8'd0;
          err_d   = 1'b0;
          state_d = S_WDATA;
        end
      end
      S_RWAIT: begin
        if (lat_q == 8'd0) state_d = S_RDATA;
        else               lat_d   = lat_q - 8'd1;
      end
      S_RDATA: begin
        rvalid = 1'b1;
        // Array read runs one beat ahead so the next word is ready on the following cycle.
        if (io_slave_rready) begin
          beat_d  = beat_q + 8'd1;
          addr_d  = nxt_addr;
          rd_addr = nxt_addr;
          if (beat_q == len_q) state_d = S_IDLE;
        end
      end
      S_WDATA: begin
        wready = 1'b1;
        if (io_slave_wvalid) begin
          we     = in_range;
          beat_d = beat_q + 8'd1;
          addr_d = nxt_addr;
          if (!in_range) err_d = 1'b1;
          if (io_slave_wlast) begin
            if (beat_q != len_q) err_d = 1'b1;
            state_d = S_BRESP;
          end
        end
      end
      S_BRESP: begin
        bvalid = 1'b1;
        if (io_slave_bready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      id_q    <= '0;
      len_q   <= '0;
      burst_q <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      err_q   <= err_d;
    end
  end

  ysyx_23060236_sram_array #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_array (
    .clock  (clock),
    .raddr_i(IDX_W'((rd_addr - BASE) >> 2)),
    .rdata_o(arr_rdata),
    .we_i   (we && !reset),
    .waddr_i(IDX_W'(off >> 2)),
    .wstrb_i(io_slave_wstrb),
    .wdata_i(io_slave_wdata)
  );

  assign io_slave_arready = arready && !reset;
  assign io_slave_awready = awready && !reset;
  assign io_slave_wready  = wready && !reset;
  assign io_slave_rvalid  = rvalid && !reset;
  assign io_slave_bvalid  = bvalid && !reset;

  assign io_slave_rdata = (io_slave_rvalid && in_range) ? arr_rdata : 32'd0;
  assign io_slave_rresp = (io_slave_rvalid && !in_range) ? RESP_SLVERR : RESP_OKAY;
  assign io_slave_rlast = io_slave_rvalid && (beat_q == len_q);
  assign io_slave_rid   = io_slave_rvalid ? id_q : 4'd0;
  assign io_slave_bresp = (io_slave_bvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign io_slave_bid   = io_slave_bvalid ? id_q : 4'd0;

endmodule
